// File: rtl/chunk_adder_pkg.sv
// Shared constants for the chunked adder: FSM state encoding and index sizing.
// Combinational helpers only; no latency; no flow control.
// Imported by the interface consumers and the top-level datapath.
package chunk_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A one-slice configuration still needs a 1-bit index register.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder_if.sv
// Operand/result handshake bundle between producer, chunk_adder and consumer.
// Wires only; no latency.
// valid/ready on both the operand side and the result side.
interface chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, ovf
    );
endinterface

// File: rtl/chunk_adder_add_slice.sv
// CHUNK-bit ripple adder slice with carry in and carry out.
// Purely combinational; no latency; no flow control.
module add_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/chunk_adder.sv
// Sequential WIDTH-bit add/subtract, CHUNK bits per cycle with a registered carry.
// Latency NCHUNK cycles from acceptance edge to out_valid; II = NCHUNK+2.
// Result held in DONE until out_ready; operands accepted only in IDLE.
module chunk_adder
    import chunk_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic          clk,
    input logic          rst,
    chunk_adder_if.slave bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_lo;
    logic             cout_q;
    logic             ovf_q;

    logic [CHUNK-1:0] slice_s;
    logic             slice_c;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [WIDTH-1:0] sum_next;
    logic             last;
    logic             slice_ovf;

    add_slice #(.CHUNK(CHUNK)) u_slice (
        .x    (a_q[CHUNK-1:0]),
        .y    (b_q[CHUNK-1:0]),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_c)
    );

    // Operands drain towards bit 0 and results enter from the top, so the
    // slice adder always sees a fixed bit range.
    if (CHUNK < WIDTH) begin : g_shift
        assign a_shift  = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
        assign b_shift  = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
        assign sum_next = {slice_s, sum_lo[WIDTH-1:CHUNK]};
    end else begin : g_single
        assign a_shift  = '0;
        assign b_shift  = '0;
        assign sum_next = slice_s;
    end

    assign last = (idx == LAST_IDX);

    // On the last slice the top operand bits sit in the slice's MSB position.
    assign slice_ovf = (a_q[CHUNK-1] == b_q[CHUNK-1]) && (slice_s[CHUNK-1] != a_q[CHUNK-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sum_lo <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b ^ {WIDTH{bus.sub}};
                        carry <= bus.sub;
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_q    <= a_shift;
                    b_q    <= b_shift;
                    sum_lo <= sum_next;
                    carry  <= slice_c;
                    if (last) begin
                        cout_q <= slice_c;
                        ovf_q  <= slice_ovf;
                        idx    <= '0;
                        state  <= ST_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE) && !rst;
    assign bus.out_valid = (state == ST_DONE);
    assign bus.sum       = {cout_q, sum_lo};
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_chunk_adder.sv
// Bench for chunk_adder: directed checks on a 16/4 instance plus random sweeps
// over four WIDTH/CHUNK configurations against an arithmetic reference.
module tb_chunk_adder;

    typedef struct {
        logic [63:0] sum;
        logic        ovf;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_s;
    logic rst_d;
    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   done_cnt    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cfg_w(input int g);
        return (g == 3) ? 32 : 16;
    endfunction

    function automatic int cfg_c(input int g);
        return (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 16 : 8;
    endfunction

    // Reference: plain integer arithmetic, overflow from the true signed result range.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic sub, input int acc);
        exp_t        e;
        logic [63:0] m;
        logic [63:0] bb;
        logic [63:0] s;
        longint      sa;
        longint      sb;
        longint      tr;
        longint      lim;
        m   = (64'd1 << w) - 64'd1;
        bb  = sub ? (~b & m) : (b & m);
        s   = (a & m) + bb + {63'd0, sub};
        e.sum = s & ((64'd1 << (w + 1)) - 64'd1);
        lim = longint'(64'd1 << (w - 1));
        sa  = a[w-1] ? longint'(a & m) - 2 * lim : longint'(a & m);
        sb  = b[w-1] ? longint'(b & m) - 2 * lim : longint'(b & m);
        tr  = sub ? sa - sb : sa + sb;
        e.ovf = (tr >= lim) || (tr < -lim);
        e.acc = acc;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- random sweep instances ----------------
    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int W = cfg_w(g);
        localparam int C = cfg_c(g);
        localparam int N = W / C;

        chunk_adder_if #(.WIDTH(W)) bus ();
        chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (.clk(clk), .rst(rst_s), .bus(bus));

        exp_t q[$];
        int   seen = 0;

        always @(negedge clk) begin
            exp_t e;
            if (!rst_s) begin
                if (bus.out_valid) begin
                    if (q.size() == 0) begin
                        check($sformatf("g%0d_spurious_vld", g), bus.out_valid, 0);
                    end else begin
                        e = q[0];
                        if (seen == 0) begin
                            check($sformatf("g%0d_latency", g), cyc - e.acc, N);
                            seen = 1;
                        end
                        check($sformatf("g%0d_sum", g), bus.sum, e.sum);
                        check($sformatf("g%0d_ovf", g), bus.ovf, e.ovf);
                        check($sformatf("g%0d_in_rdy_done", g), bus.in_ready, 0);
                        if (bus.out_ready) begin
                            void'(q.pop_front());
                            seen = 0;
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready)
                    q.push_back(model(W, bus.a, bus.b, bus.sub, cyc + 1));
            end
        end

        initial begin
            bus.out_ready = 1'b0;
            wait (rst_s === 1'b0);
            forever begin
                @(posedge clk); #1;
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end
        end

        initial begin
            int t;
            bus.in_valid = 1'b0;
            bus.a = '0;
            bus.b = '0;
            bus.sub = 1'b0;
            wait (rst_s === 1'b0);
            for (int n = 0; n < 1000; n++) begin
                @(posedge clk); #1;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                bus.a = W'({$urandom(), $urandom()});
                bus.b = W'({$urandom(), $urandom()});
                bus.sub = $urandom_range(0, 1) == 1;
                bus.in_valid = 1'b1;
                t = 0;
                do begin @(negedge clk); t++; end while (!bus.in_ready && t < 500);
                if (t >= 500) check($sformatf("g%0d_accept_timeout", g), t, 0);
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                bus.a = W'({$urandom(), $urandom()});
                bus.b = W'({$urandom(), $urandom()});
                bus.sub = ~bus.sub;
            end
            t = 0;
            while (q.size() != 0 && t < 1000) begin @(posedge clk); t++; end
            check($sformatf("g%0d_drain", g), q.size(), 0);
            done_cnt++;
        end
    end

    // ---------------- directed instance ----------------
    chunk_adder_if #(.WIDTH(16)) dbus ();
    chunk_adder #(.WIDTH(16), .CHUNK(4)) ddut (.clk(clk), .rst(rst_d), .bus(dbus));

    logic [15:0] dir_a [5] = '{16'hFFFF, 16'd123, 16'd5, 16'h7FFF, 16'h8000};
    logic [15:0] dir_b [5] = '{16'hFFFF, 16'd87,  16'd7, 16'h0001, 16'h0001};
    logic        dir_s [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [16:0] dir_e [5] = '{17'h1FFFE, 17'h000D2, 17'h0FFFE, 17'h08000, 17'h17FFF};
    logic        dir_o [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    task automatic wait_accept();
        int t = 0;
        do begin @(negedge clk); t++; end while (!dbus.in_ready && t < 50);
    endtask

    task automatic wait_result();
        int t = 0;
        do begin @(negedge clk); t++; end while (!dbus.out_valid && t < 50);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          output logic [16:0] s, output logic o, output int lat);
        int acc;
        dbus.a = a;
        dbus.b = b;
        dbus.sub = sub;
        dbus.out_ready = 1'b1;
        dbus.in_valid = 1'b1;
        wait_accept();
        acc = cyc + 1;
        @(posedge clk); #1;
        dbus.in_valid = 1'b0;
        dbus.a = 16'hDEAD;
        dbus.b = 16'hBEEF;
        dbus.sub = ~sub;
        wait_result();
        lat = cyc - acc;
        s = dbus.sum;
        o = dbus.ovf;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [16:0] s;
        logic        o;
        int          lat;
        int          acc1;
        int          acc2;
        int          bad;
        int          t;
        exp_t        e;

        rst_s = 1'b1;
        rst_d = 1'b1;
        dbus.in_valid = 1'b0;
        dbus.out_ready = 1'b0;
        dbus.a = '0;
        dbus.b = '0;
        dbus.sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", dbus.in_ready, 0);
        check("rst_out_valid", dbus.out_valid, 0);
        check("rst_sum", dbus.sum, 0);
        check("rst_ovf", dbus.ovf, 0);
        @(posedge clk); #1;
        rst_d = 1'b0;
        rst_s = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", dbus.in_ready, 1);
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            e = model(16, dir_a[i], dir_b[i], dir_s[i], 0);
            check($sformatf("model_pin%0d_sum", i), e.sum, dir_e[i]);
            check($sformatf("model_pin%0d_ovf", i), e.ovf, dir_o[i]);
            run_op(dir_a[i], dir_b[i], dir_s[i], s, o, lat);
            check($sformatf("dir%0d_sum", i), s, dir_e[i]);
            check($sformatf("dir%0d_ovf", i), o, dir_o[i]);
            check($sformatf("dir%0d_latency", i), lat, 4);
        end

        // Backpressure: result must hold while out_ready stays low.
        dbus.a = 16'h1234;
        dbus.b = 16'h1111;
        dbus.sub = 1'b0;
        dbus.out_ready = 1'b0;
        dbus.in_valid = 1'b1;
        wait_accept();
        @(posedge clk); #1;
        dbus.in_valid = 1'b0;
        wait_result();
        for (int i = 0; i < 10; i++) begin
            check("bp_sum", dbus.sum, 17'h02345);
            check("bp_out_valid", dbus.out_valid, 1);
            check("bp_in_ready", dbus.in_ready, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        dbus.out_ready = 1'b1;
        @(negedge clk);
        check("take_cycle_in_ready", dbus.in_ready, 0);
        check("take_cycle_sum", dbus.sum, 17'h02345);
        @(negedge clk);
        check("after_take_in_ready", dbus.in_ready, 1);
        check("after_take_out_valid", dbus.out_valid, 0);
        @(posedge clk); #1;

        // Back-to-back operations with in_valid held high.
        dbus.a = 16'd1;
        dbus.b = 16'd2;
        dbus.in_valid = 1'b1;
        acc1 = -1;
        acc2 = -1;
        for (int i = 0; i < 40 && acc2 < 0; i++) begin
            @(negedge clk);
            if (dbus.in_ready) begin
                if (acc1 < 0) begin
                    acc1 = cyc + 1;
                    @(posedge clk); #1;
                    dbus.a = 16'h00F0;
                    dbus.b = 16'h000F;
                end else begin
                    acc2 = cyc + 1;
                end
            end
        end
        check("initiation_interval", acc2 - acc1, 6);
        @(posedge clk); #1;
        dbus.in_valid = 1'b0;
        wait_result();
        check("b2b_second_sum", dbus.sum, 17'h000FF);
        @(posedge clk); #1;

        // Reset during RUN at idx=2 must discard the operation.
        dbus.a = 16'h0009;
        dbus.b = 16'h0009;
        dbus.in_valid = 1'b1;
        wait_accept();
        @(posedge clk); #1;
        dbus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_d = 1'b1;
        @(posedge clk); #1;
        rst_d = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dbus.out_valid) bad++;
        end
        check("abort_no_out_valid", bad, 0);
        @(posedge clk); #1;
        run_op(16'd3, 16'd4, 1'b0, s, o, lat);
        check("post_abort_sum", s, 17'd7);
        check("post_abort_latency", lat, 4);

        t = 0;
        while (done_cnt < 4 && t < 80000) begin @(posedge clk); t++; end
        check("sweep_complete", done_cnt, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/chunk_adder.md
# chunk_adder

Multi-cycle parametrised adder/subtractor that adds two WIDTH-bit operands CHUNK bits per clock, carrying between slices in a register. It is the sequential successor to the team's single-cycle parametrised adder. It trades latency for a short carry chain and adds a subtract mode, a signed-overflow flag and valid/ready handshakes on both sides. It sits between an operand producer and a result consumer in datapath experiments where WIDTH is too wide for a one-cycle ripple.

## Interface
- WIDTH, 16: operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4: bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK: number of RUN cycles.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- sub  in  1  0: a+b; 1: a-b, computed as a + ~b + 1.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH+1  result; sum[WIDTH] is the carry-out. In subtract mode it is the not-borrow bit: 1 means a ≥ b unsigned.
- ovf  out  1  signed overflow of the WIDTH-bit result.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch a, b^{WIDTH{sub}} and sub.
  - Carry register takes the value of sub.
  - Chunk index idx=0; go to RUN.
- RUN:
  - Each cycle, add slice idx of a, slice idx of the (possibly inverted) b, and carry.
  - Write the CHUNK result bits into sum[idx*CHUNK +: CHUNK].
  - Update carry; idx++.
  - At idx==NCHUNK-1, write the final slice, set sum[WIDTH]=carry-out and go to DONE.
- ovf is captured with the last slice: (a[W-1]==b'[W-1]) && (result[W-1]!=a[W-1]), where b' is the inverted operand when sub=1.
- DONE:
  - out_valid=1; sum and ovf are held stable.
  - On out_valid&&out_ready, go to IDLE.
- in_ready and out_valid are decoded from the state only. in_ready is forced to 0 while rst=1.
- No same-cycle turnaround: in_ready is 0 in the DONE cycle in which the result is taken.
- Inputs a, b and sub are ignored outside the accepting edge; changing them during RUN has no effect.
- Reset:
  - state=IDLE, idx=0, carry=0, sum=0, ovf=0, out_valid=0.
  - in_ready=1 from the first cycle after rst deasserts.
  - Reset mid-RUN or in DONE aborts the operation; the result is discarded and never presented.
- Arithmetic is modulo 2^(WIDTH+1) on sum. No saturation.

## Timing
- Acceptance edge E0. Slice i is written at edge E(i+1).
- out_valid rises in the cycle after edge E_NCHUNK, giving a latency of NCHUNK cycles from acceptance to first out_valid.
- sum and ovf are valid whenever out_valid=1. Their values during RUN are undefined to the consumer.
- Minimum initiation interval is NCHUNK+2 cycles: accept, NCHUNK RUN cycles, one DONE cycle with out_ready=1.
- Backpressure: DONE holds indefinitely while out_ready=0.
- CHUNK==WIDTH: NCHUNK=1, giving a single RUN cycle.
- The critical path is one CHUNK-bit ripple plus the carry register.

## Structure
- Shared package holds:
  - the state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - a clog2-based width function for idx, sized $clog2(NCHUNK) with a minimum of 1 bit.
- One sub-module, add_slice #(CHUNK): a combinational CHUNK-bit adder with ports x, y, cin, s, cout, instantiated once.
- Operand registers are shifted right by CHUNK per RUN cycle so that add_slice always reads bits [CHUNK-1:0]. This avoids variable part-selects on the inputs. sum is assembled by shifting in from the top.

## Test plan
- WIDTH=16, CHUNK=4, a=16'hFFFF, b=16'hFFFF, sub=0, out_ready=1 -> sum=17'h1FFFE, ovf=0, out_valid exactly 4 cycles after acceptance.
- a=123, b=87, sub=0 -> sum=210; a=5, b=7, sub=1 -> sum=17'h0FFFE (sum[16]=0, borrow), ovf=0.
- a=16'h7FFF, b=1, sub=0 -> sum=17'h08000, ovf=1; a=16'h8000, b=1, sub=1 -> sum=17'h17FFF, ovf=1.
- Backpressure check, with a=16'h1234, b=16'h1111:
  - Hold out_ready=0 for 10 cycles in DONE -> sum=17'h02345 stable and in_ready=0 throughout.
  - Raise out_ready -> in_ready=1 on the next cycle.
  - A back-to-back second op is accepted no sooner than NCHUNK+2 cycles after the first.
- Assert rst for 1 cycle at RUN idx=2, then start a=3, b=4 -> first op never produces out_valid; second returns sum=7.
- Parameter sweep with CHUNK=1, 4 and 16 (WIDTH=16) plus WIDTH=32/CHUNK=8, over 1000 random a/b/sub each. Check that sum equals the reference a+b or a+~b+1 in WIDTH+1 bits, that ovf matches, and that latency equals NCHUNK.
